// File: rtl/atu_rw_arbiter_pkg.sv
// Shared frontend types and default tuning for the ATU read/write arbiter.
// Watermarks, starvation bound and drain-burst length live here so all users agree.
package atu_rw_arbiter_pkg;

   typedef enum logic {
      RD_MODE  = 1'b0,
      WR_DRAIN = 1'b1
   } arb_mode_e;

   localparam int DEF_AXI_ADDRWIDTH = 32;
   localparam int DEF_WQ_DEPTH      = 16;
   localparam int DEF_WR_HIGH_WM    = 12;
   localparam int DEF_WR_LOW_WM     = 4;
   localparam int DEF_STARVE_LIMIT  = 64;
   localparam int DEF_MAX_WR_BURST  = 8;

endpackage

// File: rtl/atu_rw_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Value is registered and updates one cycle after clr/inc; holds at LIMIT.
module sat_counter #(
   parameter int WIDTH = 4,
   parameter int LIMIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic at_limit;

   assign at_limit = (cnt == WIDTH'(LIMIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !at_limit) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/atu_rw_arbiter.sv
// Shares the single ATU between the AXI read and write queues using watermark-driven modes.
// Selection and pops are zero-latency (combinational on atuAccept); mode/counters change at the edge.
module atu_rw_arbiter
   import atu_rw_arbiter_pkg::*;
#(
   parameter int AXI_ADDRWIDTH = DEF_AXI_ADDRWIDTH,
   parameter int WQ_DEPTH      = DEF_WQ_DEPTH,
   parameter int WQ_CNT_BIT    = $clog2(WQ_DEPTH + 1),
   parameter int WR_HIGH_WM    = DEF_WR_HIGH_WM,
   parameter int WR_LOW_WM     = DEF_WR_LOW_WM,
   parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT,
   parameter int STARVE_BIT    = $clog2(STARVE_LIMIT + 1),
   parameter int MAX_WR_BURST  = DEF_MAX_WR_BURST
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdReqValid,
   input  logic [AXI_ADDRWIDTH-1:0] rdReqAddr,
   output logic                     rdReqPop,
   input  logic                     wrReqValid,
   input  logic [AXI_ADDRWIDTH-1:0] wrReqAddr,
   output logic                     wrReqPop,
   input  logic [WQ_CNT_BIT-1:0]    wrQueueCount,
   output logic                     atuReadValid,
   output logic [AXI_ADDRWIDTH-1:0] atuReadAddr,
   output logic                     atuWriteValid,
   output logic [AXI_ADDRWIDTH-1:0] atuWriteAddr,
   input  logic                     atuAccept,
   output logic                     wrDrainMode,
   output logic                     starveForce
);

   localparam int BURST_BIT = $clog2(MAX_WR_BURST + 1);

   if (WR_LOW_WM >= WR_HIGH_WM) begin : g_wm_order_check
      $error("atu_rw_arbiter: WR_LOW_WM must be below WR_HIGH_WM");
   end

   arb_mode_e              mode;
   arb_mode_e              mode_nxt;
   logic                   sel_rd;
   logic                   sel_wr;
   logic                   starve_cond;
   logic                   starve_hit;
   logic                   starve_force;
   logic                   enter_drain;
   logic                   wm_high;
   logic                   wm_low;
   logic                   burst_done;
   logic                   in_drain;
   logic [STARVE_BIT-1:0]  starve_cnt;
   logic [BURST_BIT-1:0]   burst_cnt;

   assign in_drain = (mode == WR_DRAIN);

   // Preferred side follows the registered mode; the other side fills idle slots.
   always_comb begin
      sel_rd = 1'b0;
      sel_wr = 1'b0;
      if (!rst) begin
         if (in_drain) begin
            sel_wr = wrReqValid;
            sel_rd = rdReqValid && !wrReqValid;
         end else begin
            sel_rd = rdReqValid;
            sel_wr = wrReqValid && !rdReqValid;
         end
      end
   end

   assign atuReadValid  = sel_rd;
   assign atuWriteValid = sel_wr;
   assign atuReadAddr   = rdReqAddr;
   assign atuWriteAddr  = wrReqAddr;
   assign rdReqPop      = sel_rd && atuAccept;
   assign wrReqPop      = sel_wr && atuAccept;

   assign wm_high     = (wrQueueCount >= WQ_CNT_BIT'(WR_HIGH_WM));
   assign wm_low      = (wrQueueCount <= WQ_CNT_BIT'(WR_LOW_WM));
   assign starve_cond = !in_drain && wrReqValid && !wrReqPop;
   assign starve_hit  = starve_cond && (starve_cnt == STARVE_BIT'(STARVE_LIMIT - 1));
   assign burst_done  = (burst_cnt == BURST_BIT'(MAX_WR_BURST));

   always_comb begin
      mode_nxt     = mode;
      enter_drain  = 1'b0;
      starve_force = 1'b0;
      case (mode)
         RD_MODE: begin
            if (wm_high || starve_hit) begin
               mode_nxt     = WR_DRAIN;
               enter_drain  = 1'b1;
               starve_force = starve_hit;
            end
         end
         WR_DRAIN: begin
            // A full queue never satisfies the burst-yield term because it is above the high mark.
            if (!wrReqValid || wm_low || (burst_done && rdReqValid && !wm_high)) begin
               mode_nxt = RD_MODE;
            end
         end
      endcase
   end

   assign starveForce = starve_force && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         mode <= RD_MODE;
      end else begin
         mode <= mode_nxt;
      end
   end

   assign wrDrainMode = in_drain;

   sat_counter #(
      .WIDTH (STARVE_BIT),
      .LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk (clk),
      .rst (rst),
      .clr (wrReqPop || in_drain),
      .inc (starve_cond),
      .cnt (starve_cnt)
   );

   sat_counter #(
      .WIDTH (BURST_BIT),
      .LIMIT (MAX_WR_BURST)
   ) u_burst_cnt (
      .clk (clk),
      .rst (rst),
      .clr (enter_drain),
      .inc (wrReqPop && in_drain),
      .cnt (burst_cnt)
   );

endmodule

// File: tb/tb_atu_rw_arbiter.sv
// Randomised and scenario-driven bench for atu_rw_arbiter with a queue-level reference model.
// Expected per-cycle observations go into a scoreboard that a negedge monitor drains.
module tb_atu_rw_arbiter;

   localparam int AW       = 32;
   localparam int CW       = 5;
   localparam int QDEPTH   = 16;
   localparam int HIGH_WM  = 12;
   localparam int LOW_WM   = 4;
   localparam int STARVE   = 64;
   localparam int BURST    = 8;

   logic          clk;
   logic          rst;
   logic          rdReqValid;
   logic [AW-1:0] rdReqAddr;
   logic          rdReqPop;
   logic          wrReqValid;
   logic [AW-1:0] wrReqAddr;
   logic          wrReqPop;
   logic [CW-1:0] wrQueueCount;
   logic          atuReadValid;
   logic [AW-1:0] atuReadAddr;
   logic          atuWriteValid;
   logic [AW-1:0] atuWriteAddr;
   logic          atuAccept;
   logic          wrDrainMode;
   logic          starveForce;

   atu_rw_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .rdReqValid    (rdReqValid),
      .rdReqAddr     (rdReqAddr),
      .rdReqPop      (rdReqPop),
      .wrReqValid    (wrReqValid),
      .wrReqAddr     (wrReqAddr),
      .wrReqPop      (wrReqPop),
      .wrQueueCount  (wrQueueCount),
      .atuReadValid  (atuReadValid),
      .atuReadAddr   (atuReadAddr),
      .atuWriteValid (atuWriteValid),
      .atuWriteAddr  (atuWriteAddr),
      .atuAccept     (atuAccept),
      .wrDrainMode   (wrDrainMode),
      .starveForce   (starveForce)
   );

   typedef struct packed {
      logic          rv;
      logic          wv;
      logic [AW-1:0] ra;
      logic [AW-1:0] wa;
      logic          rp;
      logic          wp;
      logic          dm;
      logic          sf;
   } obs_t;

   obs_t          sb[$];
   logic [AW-1:0] rdq[$];
   logic [AW-1:0] wrq[$];

   // Model state: draining flag, cycles the head write has waited unserved, writes served this drain.
   bit m_drain;
   int m_wait;
   int m_served;

   int checks;
   int errors;
   int n_sf;
   int n_drain_cycles;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   obs_t got;
   obs_t exp_o;

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_o = sb.pop_front();
         got = '{rv: atuReadValid, wv: atuWriteValid, ra: atuReadAddr, wa: atuWriteAddr,
                 rp: rdReqPop, wp: wrReqPop, dm: wrDrainMode, sf: starveForce};
         checks++;
         if (exp_o.sf) n_sf++;
         if (exp_o.dm) n_drain_cycles++;
         if (got !== exp_o) begin
            errors++;
            if (errors <= 20)
               $display("FAIL cycle_obs t=%0t got rv=%b wv=%b rp=%b wp=%b dm=%b sf=%b ra=%h wa=%h required rv=%b wv=%b rp=%b wp=%b dm=%b sf=%b ra=%h wa=%h",
                        $time, got.rv, got.wv, got.rp, got.wp, got.dm, got.sf, got.ra, got.wa,
                        exp_o.rv, exp_o.wv, exp_o.rp, exp_o.wp, exp_o.dm, exp_o.sf, exp_o.ra, exp_o.wa);
         end
      end
   end

   // Apply one cycle of inputs from the bench queues, predict the DUT response, advance the model.
   task automatic step(input bit r, input bit acc, input bit add_rd, input bit add_wr);
      obs_t e;
      bit   rvld;
      bit   wvld;
      bit   waiting;
      bit   leave;
      int   cnt;
      rvld = (rdq.size() > 0);
      wvld = (wrq.size() > 0);
      cnt  = wrq.size();
      rst          = r;
      atuAccept    = acc;
      rdReqValid   = rvld;
      wrReqValid   = wvld;
      rdReqAddr    = rvld ? rdq[0] : $urandom();
      wrReqAddr    = wvld ? wrq[0] : $urandom();
      wrQueueCount = CW'(cnt);

      e    = '0;
      e.ra = rdReqAddr;
      e.wa = wrReqAddr;
      e.dm = m_drain;
      if (!r) begin
         if (m_drain) begin
            e.wv = wvld;
            e.rv = rvld && !wvld;
         end else begin
            e.rv = rvld;
            e.wv = wvld && !rvld;
         end
         e.rp = e.rv && acc;
         e.wp = e.wv && acc;
      end

      if (r) begin
         m_drain  = 0;
         m_wait   = 0;
         m_served = 0;
      end else if (!m_drain) begin
         waiting = wvld && !e.wp;
         e.sf = waiting && (m_wait == STARVE - 1);
         if (e.wp) m_wait = 0;
         else if (waiting && m_wait < STARVE) m_wait++;
         if (cnt >= HIGH_WM || e.sf) begin
            m_drain  = 1;
            m_served = 0;
         end
      end else begin
         leave = !wvld || (cnt <= LOW_WM) || (m_served == BURST && rvld && cnt < HIGH_WM);
         m_wait = 0;
         if (e.wp && m_served < BURST) m_served++;
         if (leave) m_drain = 0;
      end
      sb.push_back(e);

      if (e.rp) void'(rdq.pop_front());
      if (e.wp) void'(wrq.pop_front());
      if (add_rd && rdq.size() < QDEPTH) rdq.push_back($urandom());
      if (add_wr && wrq.size() < QDEPTH) wrq.push_back($urandom());
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int nrd, input int nwr);
      while (rdq.size() < nrd) rdq.push_back($urandom());
      while (wrq.size() < nwr) wrq.push_back($urandom());
   endtask

   int rd_rate;
   int wr_rate;
   int acc_rate;

   initial begin
      checks = 0;
      errors = 0;
      n_sf = 0;
      n_drain_cycles = 0;
      m_drain = 0;
      m_wait = 0;
      m_served = 0;
      rst = 1'b1;
      rdReqValid = 1'b0;
      rdReqAddr = '0;
      wrReqValid = 1'b0;
      wrReqAddr = '0;
      wrQueueCount = '0;
      atuAccept = 1'b0;
      @(posedge clk);
      #1;

      // Reset with traffic present: nothing may be presented or popped.
      fill(2, 3);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      rdq.delete();
      wrq.delete();
      step(0, 1, 0, 0);

      // Five reads, always accepted.
      fill(5, 0);
      for (int i = 0; i < 7; i++) step(0, 1, 0, 0);

      // Continuous reads starving a single write.
      fill(2, 1);
      for (int i = 0; i < 70; i++) step(0, 1, 1, 0);
      rdq.delete();
      step(0, 1, 0, 0);

      // Write occupancy climbs past the high mark behind reads, then drains to the low mark.
      fill(2, 0);
      for (int i = 0; i < 12; i++) step(0, 1, 1, 1);
      for (int i = 0; i < 20; i++) step(0, 1, 1, 0);
      rdq.delete();
      wrq.delete();
      step(0, 1, 0, 0);

      // Drain burst yields to reads around count 10; full queue keeps draining.
      fill(2, 12);
      for (int i = 0; i < 14; i++) step(0, 1, 1, (i % 5) != 0);
      rdq.delete();
      wrq.delete();
      step(0, 1, 0, 0);
      fill(2, QDEPTH);
      for (int i = 0; i < 20; i++) step(0, 1, 1, 1);
      wrq.delete();
      rdq.delete();
      step(0, 1, 0, 0);

      // Read held under backpressure, then accepted.
      fill(1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);

      // Reset in the middle of a drain.
      fill(2, QDEPTH);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 1);
      step(1, 1, 1, 1);
      step(1, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

      // Random traffic with changing arrival and accept rates.
      rd_rate = 50;
      wr_rate = 50;
      acc_rate = 75;
      for (int i = 0; i < 4000; i++) begin
         if (i % 200 == 0) begin
            rd_rate  = $urandom_range(0, 100);
            wr_rate  = $urandom_range(0, 100);
            acc_rate = $urandom_range(30, 100);
         end
         step($urandom_range(0, 399) == 0,
              $urandom_range(0, 99) < acc_rate,
              $urandom_range(0, 99) < rd_rate,
              $urandom_range(0, 99) < wr_rate);
      end

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got %0d pending required 0", sb.size());
      end
      checks++;
      if (n_sf == 0) begin
         errors++;
         $display("FAIL starve_seen got %0d pulses required at least 1", n_sf);
      end
      checks++;
      if (n_drain_cycles == 0) begin
         errors++;
         $display("FAIL drain_seen got %0d cycles required at least 1", n_drain_cycles);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
